// File: rtl/filter_out_formatter.sv
// Output formatter for the spatial filter: converts signed filtered pixels to unsigned
// (clamp or absolute value), tags frame position, and buffers words in a FWFT FIFO.
module filter_out_formatter #(
  parameter int PIX_BIT   = 8,
  parameter int ROW_WIDTH = 100,
  parameter int COL_WIDTH = 100,
  parameter int CNT_BIT   = 7,
  parameter int FIFO_ABIT = 4
) (
  input  logic               clk,
  input  logic               reset_in,
  input  logic               pix_in_valid,
  input  logic [PIX_BIT:0]   pix_in,
  input  logic               abs_mode,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [PIX_BIT-1:0] out_pix,
  output logic               out_sol,
  output logic               out_eol,
  output logic               out_eof,
  output logic               frame_done,
  output logic               overflow,
  output logic [FIFO_ABIT:0] fill_level
);

  localparam int DEPTH = 1 << FIFO_ABIT;
  localparam int WBIT  = PIX_BIT + 3;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]         state;
  logic [CNT_BIT-1:0] row;
  logic [CNT_BIT-1:0] col;
  logic               mode_held;
  logic               mode_eff;
  logic               is_sol;
  logic               is_eol;
  logic               is_eof;

  logic [PIX_BIT:0]   neg_mag;
  logic [PIX_BIT-1:0] conv_pix;

  logic               s1_valid;
  logic [WBIT-1:0]    s1_word;

  logic [WBIT-1:0]    mem [DEPTH];
  logic [FIFO_ABIT:0] wr_ptr;
  logic [FIFO_ABIT:0] rd_ptr;
  logic [WBIT-1:0]    head;
  logic               empty;
  logic               full;
  logic               pop;
  logic               push_ok;

  // The mode is latched on the frame's first pixel, so the first pixel itself uses the live input.
  assign mode_eff = (state == ST_IDLE) ? abs_mode : mode_held;
  assign is_sol   = (col == '0);
  assign is_eol   = (col == CNT_BIT'(COL_WIDTH - 1));
  assign is_eof   = is_eol && (row == CNT_BIT'(ROW_WIDTH - 1));

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    neg_mag  = ~pix_in + (PIX_BIT+1)'(1);
    conv_pix = pix_in[PIX_BIT-1:0];
    if (pix_in[PIX_BIT]) begin
      if (!mode_eff)             conv_pix = '0;
      else if (neg_mag[PIX_BIT]) conv_pix = '1;
      else                       conv_pix = neg_mag[PIX_BIT-1:0];
    end
  end

  // Counters advance on every accepted pixel, dropped or not, to keep frame geometry aligned.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state     <= ST_IDLE;
      row       <= '0;
      col       <= '0;
      mode_held <= 1'b0;
    end else if (pix_in_valid) begin
      if (state == ST_IDLE) mode_held <= abs_mode;
      if (is_eol) begin
        col <= '0;
        if (is_eof) begin
          row   <= '0;
          state <= ST_IDLE;
        end else begin
          row   <= row + CNT_BIT'(1);
          state <= ST_ACTIVE;
        end
      end else begin
        col   <= col + CNT_BIT'(1);
        state <= ST_ACTIVE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
    end else begin
      s1_valid <= pix_in_valid;
      if (pix_in_valid) s1_word <= {conv_pix, is_sol, is_eol, is_eof};
    end
  end

  assign fill_level = wr_ptr - rd_ptr;
  assign empty      = (fill_level == '0);
  assign full       = (fill_level == (FIFO_ABIT+1)'(DEPTH));
  assign pop        = !empty && out_ready;
  assign push_ok    = s1_valid && (!full || pop);
  assign head       = mem[rd_ptr[FIFO_ABIT-1:0]];

  // NOTE: the storage array carries no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[FIFO_ABIT-1:0]] <= s1_word;
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (FIFO_ABIT+1)'(1);
      if (pop)     rd_ptr <= rd_ptr + (FIFO_ABIT+1)'(1);
      if (s1_valid && full && !pop) overflow <= 1'b1;
      frame_done <= pop && head[0];
    end
  end

  // Head fields are masked while empty so unwritten storage never reaches the outputs.
  assign out_valid = !empty;
  assign {out_pix, out_sol, out_eol, out_eof} = out_valid ? head : '0;

endmodule

// File: tb/tb_filter_out_formatter.sv
// Directed bench for filter_out_formatter: a software model pushes expected words into a
// scoreboard queue as pixels are driven; a negedge monitor pops and compares popped words.
module tb_filter_out_formatter;

  localparam int PIX_BIT   = 8;
  localparam int ROW_WIDTH = 100;
  localparam int COL_WIDTH = 100;
  localparam int CNT_BIT   = 7;
  localparam int FIFO_ABIT = 4;

  typedef logic [PIX_BIT+2:0] word_t;

  logic               clk = 1'b0;
  logic               reset_in;
  logic               pix_in_valid;
  logic [PIX_BIT:0]   pix_in;
  logic               abs_mode;
  logic               out_ready;
  logic               out_valid;
  logic [PIX_BIT-1:0] out_pix;
  logic               out_sol;
  logic               out_eol;
  logic               out_eof;
  logic               frame_done;
  logic               overflow;
  logic [FIFO_ABIT:0] fill_level;

  word_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    m_row = 0;
  int    m_col = 0;
  bit    m_mode = 1'b0;
  int    n_pop = 0;
  int    n_fd = 0;
  bit    fd_exp = 1'b0;

  filter_out_formatter #(
    .PIX_BIT(PIX_BIT), .ROW_WIDTH(ROW_WIDTH), .COL_WIDTH(COL_WIDTH),
    .CNT_BIT(CNT_BIT), .FIFO_ABIT(FIFO_ABIT)
  ) dut (
    .clk(clk), .reset_in(reset_in), .pix_in_valid(pix_in_valid), .pix_in(pix_in),
    .abs_mode(abs_mode), .out_ready(out_ready), .out_valid(out_valid), .out_pix(out_pix),
    .out_sol(out_sol), .out_eol(out_eol), .out_eof(out_eof), .frame_done(frame_done),
    .overflow(overflow), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference conversion and position tagging, advancing the model's own frame counters.
  task automatic model_push(input int v, input bit keep);
    int p;
    bit sol, eol, eof;
    if (m_row == 0 && m_col == 0) m_mode = abs_mode;
    p = v;
    if (p < 0) p = m_mode ? -p : 0;
    if (p > 255) p = 255;
    sol = (m_col == 0);
    eol = (m_col == COL_WIDTH - 1);
    eof = eol && (m_row == ROW_WIDTH - 1);
    if (keep) exp_q.push_back({p[PIX_BIT-1:0], sol, eol, eof});
    if (eol) begin
      m_col = 0;
      m_row = eof ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic send(input int v, input bit keep = 1'b1);
    pix_in_valid = 1'b1;
    pix_in       = v[PIX_BIT:0];
    model_push(v, keep);
    @(posedge clk);
    #1;
    pix_in_valid = 1'b0;
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_row = 0;
    m_col = 0;
  endtask

  task automatic apply_reset();
    reset_in = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    reset_in = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin : monitor
    word_t e;
    if (!reset_in) begin
      fd_exp = 1'b0;
    end else begin
      check("frame_done", frame_done, fd_exp);
      if (frame_done) n_fd++;
      fd_exp = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("word", {out_pix, out_sol, out_eol, out_eof}, e);
        end
        n_pop++;
        fd_exp = out_eof;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int fdb;
    reset_in     = 1'b0;
    pix_in_valid = 1'b0;
    pix_in       = '0;
    abs_mode     = 1'b0;
    out_ready    = 1'b0;

    // Reset held for 10 cycles, then released
    repeat (10) begin
      @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_fill", fill_level, 0);
      check("rst_ovf", overflow, 0);
      check("rst_fd", frame_done, 0);
    end
    @(posedge clk);
    #1;
    reset_in = 1'b1;
    @(negedge clk);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_fill", fill_level, 0);

    // Clamp mode with two-cycle latency
    apply_reset();
    abs_mode  = 1'b0;
    out_ready = 1'b1;
    send(-5);
    check("lat_edge_k", out_valid, 0);
    send(0);
    check("lat_edge_k1", out_valid, 1);
    send(200);
    send(255);
    send(-256);
    wait_drain("clamp_drain");

    // Abs mode, with a mid-frame mode toggle that must be ignored
    apply_reset();
    abs_mode = 1'b1;
    send(-5);
    abs_mode = 1'b0;
    send(-256);
    send(255);
    send(17);
    wait_drain("abs_drain");

    // Full frame of random pixels, then the start of a second frame in abs mode
    apply_reset();
    abs_mode = 1'b0;
    base = n_pop;
    fdb  = n_fd;
    for (int i = 0; i < ROW_WIDTH * COL_WIDTH; i++)
      send(int'($urandom_range(511)) - 256);
    wait_drain("frame_drain");
    check("frame_words", n_pop - base, ROW_WIDTH * COL_WIDTH);
    check("frame_done_count", n_fd - fdb, 1);
    abs_mode = 1'b1;
    send(-7);
    send(3);
    wait_drain("frame2_drain");

    // Backpressure and overflow: only the first 16 of 20 pixels survive
    apply_reset();
    abs_mode  = 1'b0;
    out_ready = 1'b0;
    for (int v = 1; v <= 17; v++) send(v, v <= 16);
    check("full_fill", fill_level, 16);
    check("full_no_ovf", overflow, 0);
    for (int v = 18; v <= 20; v++) send(v, 1'b0);
    check("ovf_set", overflow, 1);
    check("ovf_fill", fill_level, 16);
    check("hold_pix", out_pix, 1);
    check("hold_sol", out_sol, 1);
    @(posedge clk);
    #1;
    check("ovf_fill_after", fill_level, 16);
    out_ready = 1'b1;
    wait_drain("ovf_drain");
    for (int v = 21; v <= 120; v++) send(v);
    wait_drain("post_ovf_drain");
    check("ovf_sticky", overflow, 1);

    // Asynchronous reset mid-frame with words buffered
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 142; i++) send(i);
    wait_drain("pre_midrst_drain");
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(i);
    @(posedge clk);
    #1;
    check("midrst_fill", fill_level, 8);
    reset_in = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_fill0", fill_level, 0);
    model_clear();
    @(posedge clk);
    #1;
    reset_in  = 1'b1;
    out_ready = 1'b1;
    fdb = n_fd;
    for (int i = 0; i < ROW_WIDTH * COL_WIDTH; i++) send(i % 256);
    wait_drain("midrst_frame_drain");
    check("midrst_frame_done", n_fd - fdb, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/filter_out_formatter.md
Name: filter_out_formatter

Overview:
Downstream stage of the spatial filter core. Consumes the signed filtered pixel stream (pix_out_valid/pix_out, PIX_BIT+1 bits sign+magnitude range) and converts it to unsigned PIX_BIT-bit pixels, either clamped or absolute-valued. It tags each pixel with start-of-line, end-of-line and end-of-frame markers, then buffers the result in a small FIFO with a ready/valid output. The filter has no backpressure, so FIFO overrun is flagged rather than stalled.

Parameters:
PIX_BIT, 8, unsigned output pixel width; input is PIX_BIT+1 bits signed
ROW_WIDTH, 100, rows per frame
COL_WIDTH, 100, pixels per row
CNT_BIT, 7, row/column counter width; must satisfy 2^CNT_BIT >= max(ROW_WIDTH, COL_WIDTH)
FIFO_ABIT, 4, FIFO address bits; depth = 2^FIFO_ABIT (16)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_in  in  1  asynchronous, active-low reset
pix_in_valid  in  1  filtered pixel valid (from filter pix_out_valid)
pix_in  in  PIX_BIT+1  signed filtered pixel (from filter pix_out)
abs_mode  in  1  0 = clamp negatives to 0; 1 = absolute value (edge filters)
out_ready  in  1  downstream accepts the word
out_valid  out  1  FIFO head valid
out_pix  out  PIX_BIT  unsigned pixel
out_sol  out  1  head word is column 0
out_eol  out  1  head word is column COL_WIDTH-1
out_eof  out  1  head word is last pixel of frame
frame_done  out  1  one-cycle pulse when the eof word is popped
overflow  out  1  sticky: a pixel was dropped on a full FIFO
fill_level  out  FIFO_ABIT+1  words in FIFO

Behaviour:
- Reset (reset_in=0, asynchronous): all outputs 0; FIFO empty; row/col counters 0; conversion register invalid; overflow cleared. Reset is the only way to clear overflow.
- Stage 1 (conversion register): on each rising edge with pix_in_valid=1, register the converted value and the position tags.
  - Clamp mode: negative -> 0; otherwise the low PIX_BIT bits pass through. Max input is 2^PIX_BIT-1, so no upper saturation.
  - Abs mode: |pix_in|, saturated to 2^PIX_BIT-1. Example: -256 -> 255.
- abs_mode is sampled when the first pixel of a frame is accepted (row=0, col=0) and held for that frame. Changes mid-frame are ignored.
- Position counters advance on every accepted pix_in_valid, including pixels later dropped, so frame geometry stays aligned.
  - col increments 0..COL_WIDTH-1; at wrap, row increments 0..ROW_WIDTH-1.
  - After the eof pixel, both counters return to 0.
  - Tags: sol = (col==0); eol = (col==COL_WIDTH-1); eof = eol && (row==ROW_WIDTH-1).
- Frame state machine:
  - IDLE (row=col=0, no pixel yet) -> ACTIVE on the first valid pixel.
  - ACTIVE -> IDLE after the eof pixel is accepted.
  - Gaps in pix_in_valid do not change state.
- Stage 2 (FIFO):
  - First-word-fall-through, width PIX_BIT+3 (pixel + sol/eol/eof), depth 2^FIFO_ABIT.
  - The stage-1 word is written on the next edge.
  - out_valid = not empty; out_pix and tags reflect the head combinationally from registers.
- Latency: pixel sampled at edge k; out_valid=1 after edge k+1 (2 cycles) when the FIFO was empty.
- Pop: on each edge with out_valid && out_ready.
- Push while full:
  - Without a simultaneous pop: word dropped, overflow set, fill_level stays at 2^FIFO_ABIT.
  - With a simultaneous pop: push accepted, no overflow.
- Simultaneous push and pop on a non-full FIFO: fill_level unchanged. On an empty FIFO: the word appears next cycle (no bypass).
- frame_done: asserted for the cycle after the edge that pops an eof word.
- out_ready deasserted with out_valid=1: head word and tags held stable.
- Reset mid-frame: FIFO contents discarded; the next pixel is tagged row 0 / col 0 (sol=1).

Test Plan:
1. Reset check: hold reset_in=0 for 10 cycles, then release -> out_valid=0, fill_level=0, overflow=0, frame_done=0 throughout.
2. Clamp mode (abs_mode=0, out_ready=1): inputs -5, 0, 200, 255, -256 -> out_pix 0, 0, 200, 255, 0. First out_valid is 2 cycles after the first input; out_sol=1 on the first word only.
3. Abs mode (abs_mode=1): inputs -5, -256, 255, 17 -> out_pix 5, 255, 255, 17. Toggling abs_mode mid-frame has no effect on that frame.
4. Full 100x100 frame, continuous input, out_ready=1:
   - Exactly 10000 outputs, matching a software clamp model of the stimulus.
   - out_sol on words 0, 100, 200, ...; out_eol on 99, 199, ...; out_eof only on word 9999.
   - frame_done pulses once.
   - A second frame restarts with sol=1 at row 0.
5. Backpressure/overflow: out_ready=0, push 20 pixels valued 1..20 -> fill_level=16, overflow=1 after the 17th write. Raise out_ready -> values 1..16 in order. Then push 100 more -> column tags continue from col 20, proving counters advanced past the dropped pixels.
6. Reset mid-frame: assert reset_in after 150 pixels with 8 buffered -> out_valid drops immediately (async). After release, the next pixel has out_sol=1 and frame eof occurs 10000 pixels later.
